bw_multiplier_s: RTL and testbench
==================================

Name: bw_multiplier_s

Overview:
Signed two's-complement array multiplier built on the Baugh-Wooley scheme, with a registered product output.
- Takes two numBit-wide signed operands and produces their full 2*numBit-wide signed product one clock after sampling.
- Used as a datapath arithmetic leaf: combinational partial-product array, then a single output register.

Parameters:
numBit, 4, operand width in bits; legal range 2..32; output width is 2*numBit.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
m_in  input  numBit  multiplicand, signed two's complement
n_in  input  numBit  multiplier, signed two's complement
o_out  output  2*numBit  signed two's-complement product, registered

Behaviour:
- One clock, clk; reset is asynchronous and active-high (rst).
- Reset: while rst=1, o_out=0 immediately, independent of clk. After rst deasserts, the first rising clk edge loads a valid product.
- Latency: 1 cycle. At each rising clk edge with rst=0, o_out <= m_in * n_in (signed), using the m_in/n_in values present just before the edge. No valid/ready handshake; a new product is computed every cycle, throughput 1 per clock.
- Input changes between edges do not affect o_out until the next edge. o_out must never glitch between edges.
- Arithmetic: exact signed product. The full range always fits in 2*numBit bits, since (-2^(numBit-1))^2 = 2^(2*numBit-2). No overflow, saturation or truncation.
- Partial products, with N = numBit, i indexing m_in bits and j indexing n_in bits:
  - m[i] & n[j] for i,j < N-1, and for i=j=N-1.
  - ~(m[i] & n[j]) when exactly one of i,j equals N-1.
  - Each partial product is placed at weight i+j.
  - A constant 1 is added at weight N and a constant 1 at weight 2N-1.
  - Sum modulo 2^(2N).
- Array structure: reduce the partial products with a generate-based array of full/half adders and a final ripple carry row; the whole array is parameterised by numBit. Behavioural "*" must not replace the array.
- Reset mid-operation: asserting rst at any time forces o_out=0 asynchronously. Any product in flight is discarded.
- No internal state other than the o_out register.

Test Plan:
- Reset: rst=1 with m_in=4'b0101, n_in=4'b1010 -> o_out=8'h00 while rst is high, with no clock edge needed. Release rst, one edge -> o_out=8'hE2 (5*-6=-30).
- Zero/one operands, one edge per vector:
  - m_in=0000, n_in=0001 -> 8'h00.
  - m_in=0001, n_in=0000 -> 8'h00.
  - m_in=0011, n_in=0110 -> 8'h12 (18).
- Extremes:
  - m_in=1000, n_in=1000 -> 8'h40 (64).
  - m_in=1000, n_in=0111 -> 8'hC8 (-56).
  - m_in=0111, n_in=0111 -> 8'h31 (49).
  - m_in=1111, n_in=1111 -> 8'h01.
- Latency: change inputs mid-cycle from (0011,0110) to (0101,1010). o_out stays 8'h12 until the next rising edge, then becomes 8'hE2.
- Exhaustive sweep for numBit=4: all 256 operand pairs, one per cycle. o_out must equal the signed reference product one cycle later.
- Parameter check for numBit=8, with 1000 random pairs plus corners (-128*-128=16'h4000, -128*127=16'hC080) -> exact signed product one cycle later.

Source files
------------

// File: rtl/bw_multiplier_s.sv
// Baugh-Wooley signed array multiplier with a registered product.
// Carry-save rows of full adders reduce the partial products; a ripple row resolves them.
module bw_fa (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);
endmodule

module bw_multiplier_s #(
  parameter int numBit = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [numBit-1:0]     m_in,
  input  logic [numBit-1:0]     n_in,
  output logic [2*numBit-1:0]   o_out
);
  localparam int W = 2 * numBit;
  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] KST = (ONE << numBit) | (ONE << (W - 1));

  logic [W-1:0] pp [numBit];
  logic [W-1:0] prod;

  // Partial-product rows; terms pairing one sign bit with a non-sign bit are inverted.
  always_comb begin
    for (int j = 0; j < numBit; j++) begin
      pp[j] = '0;
      for (int i = 0; i < numBit; i++) begin
        pp[j][i+j] = (m_in[i] & n_in[j]) ^
                     (((i == numBit - 1) != (j == numBit - 1)) ? 1'b1 : 1'b0);
      end
    end
  end

  // Carry-save rows: each folds one more partial-product row into (sum, carry).
  for (genvar k = 0; k < numBit; k++) begin : row
    logic [W-1:0] s;
    logic [W-1:0] c;
    if (k == 0) begin : g_init
      assign s = pp[0];
      assign c = KST;
    end else begin : g_csa
      assign c[0] = 1'b0;
      for (genvar b = 0; b < W; b++) begin : bit_g
        if (b < W - 1) begin : g_fa
          bw_fa fa (
            .a  (row[k-1].s[b]),
            .b  (row[k-1].c[b]),
            .c  (pp[k][b]),
            .s  (s[b]),
            .co (c[b+1])
          );
        end else begin : g_top
          assign s[b] = row[k-1].s[b] ^ row[k-1].c[b] ^ pp[k][b];
        end
      end
    end
  end

  // Final ripple-carry row; the carry out of the top bit is the modulo wrap.
  always_comb begin
    logic cy;
    cy   = 1'b0;
    prod = '0;
    for (int b = 0; b < W; b++) begin
      prod[b] = row[numBit-1].s[b] ^ row[numBit-1].c[b] ^ cy;
      cy      = (row[numBit-1].s[b] & row[numBit-1].c[b]) |
                (row[numBit-1].s[b] & cy) |
                (row[numBit-1].c[b] & cy);
    end
  end

  // Output register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) o_out <= '0;
    else     o_out <= prod;
  end
endmodule

// File: tb/tb_bw_multiplier_s.sv
// Scoreboard bench for bw_multiplier_s at widths 4 and 8.
// Expected products are queued at issue time and popped one cycle later.
module tb_bw_multiplier_s;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  m4 = '0, n4 = '0;
  logic [7:0]  m8 = '0, n8 = '0;
  logic [7:0]  o4;
  logic [15:0] o8;

  int tests = 0;
  int fails = 0;
  logic [7:0]  q4 [$];
  logic [15:0] q8 [$];

  bw_multiplier_s #(.numBit(4)) dut4 (
    .clk(clk), .rst(rst), .m_in(m4), .n_in(n4), .o_out(o4)
  );
  bw_multiplier_s #(.numBit(8)) dut8 (
    .clk(clk), .rst(rst), .m_in(m8), .n_in(n8), .o_out(o8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: each rising edge presents the product queued one cycle earlier.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (q4.size() > 0) chk("prod4", {8'h00, o4}, {8'h00, q4.pop_front()});
      if (q8.size() > 0) chk("prod8", o8, q8.pop_front());
    end
  end

  task automatic issue4(input logic [3:0] m, input logic [3:0] n,
                        input logic [7:0] e);
    @(posedge clk);
    #2;
    m4 = m;
    n4 = n;
    q4.push_back(e);
  endtask

  task automatic issue8(input logic [7:0] m, input logic [7:0] n);
    logic signed [15:0] e;
    @(posedge clk);
    #2;
    m8 = m;
    n8 = n;
    e = $signed(m) * $signed(n);
    q8.push_back(e);
  endtask

  initial begin
    logic signed [7:0] e4;
    m4 = 4'b0101;
    n4 = 4'b1010;
    #3;
    chk("reset_o4", {8'h00, o4}, 16'h0000);
    chk("reset_o8", o8, 16'h0000);
    #20;
    rst = 1'b0;
    q4.push_back(8'hE2);

    issue4(4'b0000, 4'b0001, 8'h00);
    issue4(4'b0001, 4'b0000, 8'h00);
    issue4(4'b0011, 4'b0110, 8'h12);
    issue4(4'b1000, 4'b1000, 8'h40);
    issue4(4'b1000, 4'b0111, 8'hC8);
    issue4(4'b0111, 4'b0111, 8'h31);
    issue4(4'b1111, 4'b1111, 8'h01);

    issue4(4'b0011, 4'b0110, 8'h12);
    @(posedge clk);
    #2;
    m4 = 4'b0101;
    n4 = 4'b1010;
    #1;
    chk("hold_mid_cycle", {8'h00, o4}, 16'h0012);
    q4.push_back(8'hE2);
    @(posedge clk);
    #3;
    chk("after_edge", {8'h00, o4}, 16'h00E2);

    issue4(4'b0111, 4'b0111, 8'h31);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_reset", {8'h00, o4}, 16'h0000);
    #1;
    rst = 1'b0;

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        e4 = $signed(4'(a)) * $signed(4'(b));
        issue4(4'(a), 4'(b), e4);
      end
    end

    issue8(8'h80, 8'h80);
    issue8(8'h80, 8'h7F);
    issue8(8'h7F, 8'h7F);
    issue8(8'hFF, 8'h01);
    issue8(8'h00, 8'h80);
    for (int k = 0; k < 1000; k++) begin
      issue8(8'($urandom), 8'($urandom));
    end

    repeat (3) @(posedge clk);
    #2;
    chk("drain_q4", 16'(q4.size()), 16'h0000);
    chk("drain_q8", 16'(q8.size()), 16'h0000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
